imem_loader: RTL

Byte-stream program loader that fills the RISC-V core's instruction memory before execution. It accepts a length-prefixed little-endian byte stream (from the UART/HPS bridge on the DE1-SoC) and packs it into 32-bit words. It issues one write per word into the instruction memory's write port. It holds the CPU in reset until the image is complete and valid. It is the writer for the instruction memory that the datapath's fetch stage reads.

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/word_packer.sv | 36 +++
 rtl/imem_loader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and stream constants for the instruction-memory loader.
// Imported by imem_loader and word_packer.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // Byte address of a word slot; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/word_packer.sv
// Little-endian byte-lane packer: fills a 32-bit word one byte at a time
// and flags the byte that completes it.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_full
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] byte_index;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_index <= '0;
            word       <= '0;
        end else if (clear) begin
            byte_index <= '0;
            word       <= '0;
        end else if (shift_en) begin
            word[{byte_index, 3'b000} +: 8] <= byte_data;
            byte_index                      <= byte_index + 1'b1;
        end
    end

    assign word_full = shift_en && (byte_index == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader for the instruction memory; holds the
// core in reset until the image is in. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam int IDX_W = $clog2(MEM_WORDS) + 1;

    state_t                   state, state_nxt;
    logic [8*LEN_BYTES-1:0]   len;
    logic [8*LEN_BYTES-1:0]   len_rx;
    logic [IDX_W-1:0]         word_index;
    logic [31:0]              packed_word;
    logic                     accept;
    logic                     start_ok;
    logic                     word_full;
    logic                     last_word;

    assign accept   = byte_valid && byte_ready;
    assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign len_rx   = {byte_data, len[7:0]};
    assign last_word = (16'(word_index) == len - 16'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FINAL = S_CHECK;

    logic [7:0] csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= '0;
        end else if (start_ok) begin
            csum <= '0;
        end else if (state == S_DATA && accept) begin
            csum <= csum ^ byte_data;
        end
    end
`else
    localparam state_t S_FINAL = S_DONE;
`endif

    word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .shift_en  (state == S_DATA && accept),
        .byte_data (byte_data),
        .word      (packed_word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len        <= '0;
            word_index <= '0;
        end else if (start_ok) begin
            len        <= '0;
            word_index <= '0;
        end else begin
            if (state == S_LEN_LO && accept) len[7:0]  <= byte_data;
            if (state == S_LEN_HI && accept) len[15:8] <= byte_data;
            if (state == S_WRITE)            word_index <= word_index + 1'b1;
        end
    end

    // NOTE: next state takes a default first so no path through the case
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) begin
                    if (len_rx > 16'(MEM_WORDS)) state_nxt = S_ERROR;
                    else if (len_rx == 16'd0)    state_nxt = S_FINAL;
                    else                         state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (word_full) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                state_nxt = last_word ? S_FINAL : S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) state_nxt = (csum == byte_data) ? S_DONE : S_ERROR;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // All handshake and status outputs are pure decodes of the state register.
    assign byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                        (state == S_DATA)   || (state == S_CHECK);
    assign mem_we     = (state == S_WRITE);
    assign mem_addr   = word_addr(BASE_ADDR, 32'(word_index));
    assign mem_wdata  = packed_word;
    assign cpu_reset  = (state != S_DONE);
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERROR);

endmodule
